// File: rtl/pooling_sched.sv
// Max-pooling sequencer: walks channels x rows x words and emits the datapath ctrl/cfg words.
// Define POOLING_SCHED_PAD_EN to complete trailing partial windows with pad rows.
module pooling_sched #(
    parameter int NUM_PE     = 4,
    parameter int CTRL_WIDTH = 7,
    parameter int CFG_WIDTH  = 3,
    parameter int DIM_WIDTH  = 10,
    parameter int ROWPOP_LAT = 2,
    parameter int PIPE_LAT   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [DIM_WIDTH-1:0]  cfg_words_i,
    input  logic [DIM_WIDTH-1:0]  cfg_rows_i,
    input  logic [DIM_WIDTH-1:0]  cfg_channels_i,
    input  logic                  cfg_kernel3_i,
    input  logic [1:0]            cfg_stride_i,
    input  logic                  pool_ready_i,
    output logic [CTRL_WIDTH-1:0] ctrl_o,
    output logic [CFG_WIDTH-1:0]  cfg_o,
    output logic                  busy_o,
    output logic                  done_o
);
    localparam int RW = DIM_WIDTH + 1;
    localparam int SW = $clog2(NUM_PE) + 1;
    localparam int DW = $clog2(PIPE_LAT) + 1;

    typedef enum logic [2:0] {IDLE, WAIT, POP, SHIFT, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic [DIM_WIDTH-1:0]  words_q, words_d, rows_q, rows_d, chans_q, chans_d;
    logic                  k3_q, k3_d;
    logic [1:0]            stride_q, stride_d;
    logic [DIM_WIDTH-1:0]  word_q, word_d, ch_q, ch_d;
    logic [RW-1:0]         row_q, row_d;
    logic [1:0]            ph_q, ph_d;
    logic [SW-1:0]         sh_q, sh_d;
    logic [DW-1:0]         drn_q, drn_d;
    // {pad, row_fifo_pop} line and {push, mux_sel, valid} line
    logic [ROWPOP_LAT-1:0][1:0] rp_q, rp_d;
    logic [PIPE_LAT-1:0][2:0]   pl_q, pl_d;
    logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;

    logic [1:0]    k_max;
    logic [SW-1:0] ops;
    logic          pad_row, pad_next, in_win, chan_end;
    logic          iss_pop, iss_shift, word_end, nxt_pad, run_end;
    logic [1:0]    rp_ent;
    logic [2:0]    pl_ent;

    assign k_max = k3_q ? 2'd2 : 2'd1;
    assign ops   = (stride_q == 2'd2) ? SW'(NUM_PE / 2) : SW'(NUM_PE);

`ifdef POOLING_SCHED_PAD_EN
    // Rows past cfg_rows are pad rows; the channel ends only on a completed window.
    assign pad_row  = row_q >= {1'b0, rows_q};
    assign pad_next = (row_q + RW'(1)) >= {1'b0, rows_q};
    assign in_win   = 1'b1;
    assign chan_end = pad_next && (ph_q == k_max);
`else
    logic [RW-1:0] rem;
    logic [1:0]    need;
    // A row belongs to a complete window only if the rest of its window still exists.
    assign rem      = {1'b0, rows_q} - row_q;
    assign need     = k_max + 2'd1 - ph_q;
    assign in_win   = rem >= RW'(need);
    assign pad_row  = 1'b0;
    assign pad_next = 1'b0;
    assign chan_end = (row_q + RW'(1)) == {1'b0, rows_q};
`endif

    always_comb begin
        state_d  = state_q;
        words_d  = words_q;
        rows_d   = rows_q;
        chans_d  = chans_q;
        k3_d     = k3_q;
        stride_d = stride_q;
        word_d   = word_q;
        row_d    = row_q;
        ch_d     = ch_q;
        ph_d     = ph_q;
        sh_d     = sh_q;
        drn_d    = drn_q;
        iss_pop  = 1'b0;
        iss_shift = 1'b0;
        word_end = 1'b0;
        run_end  = 1'b0;
        nxt_pad  = pad_row;
        case (state_q)
            IDLE: if (start_i) begin
                words_d  = cfg_words_i;
                rows_d   = cfg_rows_i;
                chans_d  = cfg_channels_i;
                k3_d     = cfg_kernel3_i;
                stride_d = cfg_stride_i;
                word_d   = '0;
                row_d    = '0;
                ch_d     = '0;
                ph_d     = '0;
                state_d  = WAIT;
            end
            WAIT: if (pool_ready_i || pad_row) state_d = POP;
            POP: begin
                iss_pop = 1'b1;
                sh_d    = '0;
                if (ops > SW'(1)) state_d = SHIFT;
                else              word_end = 1'b1;
            end
            SHIFT: begin
                iss_shift = 1'b1;
                if (sh_q == ops - SW'(2)) word_end = 1'b1;
                else                      sh_d = sh_q + SW'(1);
            end
            DRAIN: if (drn_q == DW'(PIPE_LAT - 1)) state_d = DONE;
                   else                            drn_d = drn_q + DW'(1);
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (word_end) begin
            if (word_q == words_q - DIM_WIDTH'(1)) begin
                word_d = '0;
                if (!chan_end) begin
                    row_d   = row_q + RW'(1);
                    ph_d    = (ph_q == k_max) ? 2'd0 : ph_q + 2'd1;
                    nxt_pad = pad_next;
                end else begin
                    row_d   = '0;
                    ph_d    = '0;
                    nxt_pad = 1'b0;
                    if (ch_q == chans_q - DIM_WIDTH'(1)) run_end = 1'b1;
                    else                                 ch_d = ch_q + DIM_WIDTH'(1);
                end
            end else begin
                word_d = word_q + DIM_WIDTH'(1);
            end
            if (run_end) begin
                state_d = DRAIN;
                drn_d   = '0;
            end else begin
                state_d = (pool_ready_i || nxt_pad) ? POP : WAIT;
            end
        end
    end

    always_comb begin
        rp_ent = 2'b00;
        pl_ent = 3'b000;
        if (iss_pop || iss_shift) begin
            rp_ent = {iss_pop && pad_row, in_win && (ph_q != 2'd0)};
            pl_ent = {in_win && (ph_q != k_max), in_win && (ph_q == 2'd0), in_win && (ph_q == k_max)};
        end
    end

    // Delay lines shift every cycle, so stalls only insert bubbles.
    always_comb begin
        rp_d[0] = rp_ent;
        for (int i = 1; i < ROWPOP_LAT; i++) rp_d[i] = rp_q[i-1];
        pl_d[0] = pl_ent;
        for (int i = 1; i < PIPE_LAT; i++) pl_d[i] = pl_q[i-1];
        ctrl_d    = '0;
        ctrl_d[0] = iss_shift;
        ctrl_d[1] = iss_pop;
        ctrl_d[2] = pl_q[PIPE_LAT-1][2];
        ctrl_d[3] = rp_q[ROWPOP_LAT-1][0];
        ctrl_d[4] = pl_q[PIPE_LAT-1][1];
        ctrl_d[5] = pl_q[PIPE_LAT-1][0];
        ctrl_d[6] = (iss_pop && pad_row) || rp_q[ROWPOP_LAT-1][1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            words_q  <= '0;
            rows_q   <= '0;
            chans_q  <= '0;
            k3_q     <= 1'b0;
            stride_q <= '0;
            word_q   <= '0;
            row_q    <= '0;
            ch_q     <= '0;
            ph_q     <= '0;
            sh_q     <= '0;
            drn_q    <= '0;
            rp_q     <= '0;
            pl_q     <= '0;
            ctrl_q   <= '0;
        end else begin
            state_q  <= state_d;
            words_q  <= words_d;
            rows_q   <= rows_d;
            chans_q  <= chans_d;
            k3_q     <= k3_d;
            stride_q <= stride_d;
            word_q   <= word_d;
            row_q    <= row_d;
            ch_q     <= ch_d;
            ph_q     <= ph_d;
            sh_q     <= sh_d;
            drn_q    <= drn_d;
            rp_q     <= rp_d;
            pl_q     <= pl_d;
            ctrl_q   <= ctrl_d;
        end
    end

    assign ctrl_o = ctrl_q;
    assign cfg_o  = CFG_WIDTH'({k3_q, stride_q});
    assign busy_o = (state_q != IDLE) && (state_q != DONE);
    assign done_o = (state_q == DONE);

endmodule

// File: tb/tb_pooling_sched.sv
// Directed bench for pooling_sched: a per-issue-cycle scoreboard predicts every ctrl bit.
module tb_pooling_sched;
    localparam int NUM_PE = 4, CTRL_WIDTH = 7, CFG_WIDTH = 3, DIM_WIDTH = 10;
    localparam int ROWPOP_LAT = 2, PIPE_LAT = 4;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, k3 = 1'b0, ready = 1'b0;
    logic [DIM_WIDTH-1:0] words = '0, rows = '0, chans = '0;
    logic [1:0] stride = '0;
    logic [CTRL_WIDTH-1:0] ctrl;
    logic [CFG_WIDTH-1:0]  cfg;
    logic busy, done;

    pooling_sched #(.NUM_PE(NUM_PE), .CTRL_WIDTH(CTRL_WIDTH), .CFG_WIDTH(CFG_WIDTH),
                    .DIM_WIDTH(DIM_WIDTH), .ROWPOP_LAT(ROWPOP_LAT), .PIPE_LAT(PIPE_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .cfg_words_i(words), .cfg_rows_i(rows),
        .cfg_channels_i(chans), .cfg_kernel3_i(k3), .cfg_stride_i(stride), .pool_ready_i(ready),
        .ctrl_o(ctrl), .cfg_o(cfg), .busy_o(busy), .done_o(done));

    always #5 clk = ~clk;

    typedef struct packed { logic pop; logic pad; logic rpop; logic push; logic mux; logic vld; } exp_t;
    exp_t q[$];
    logic [4:0] ring [16];   // {pad, valid, mux_sel, row_fifo_pop, row_fifo_push} due per cycle
    int n_cmp = 0, n_bad = 0, cyc = 0;
    int cnt_pop = 0, cnt_vld = 0, cnt_push = 0, cnt_done = 0;
    bit mon_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected issue stream from window arithmetic (row index mod K, full windows = rows/K).
    task automatic build(input int w, input int r, input int c, input bit k3i, input int s,
                         output int e_pop, output int e_vld, output int e_push);
        int kk, ops, full, tot, ph;
        bit win;
        exp_t e;
        kk   = k3i ? 3 : 2;
        ops  = (s == 2) ? NUM_PE / 2 : NUM_PE;
        full = r / kk;
        tot  = r;
`ifdef POOLING_SCHED_PAD_EN
        if (r % kk != 0) begin
            tot  = r + kk - r % kk;
            full = tot / kk;
        end
`endif
        for (int ch = 0; ch < c; ch++)
            for (int row = 0; row < tot; row++)
                for (int wd = 0; wd < w; wd++)
                    for (int o = 0; o < ops; o++) begin
                        ph     = row % kk;
                        win    = row < full * kk;
                        e.pop  = (o == 0);
                        e.pad  = (row >= r) && (o == 0);
                        e.rpop = win && ph > 0;
                        e.push = win && ph < kk - 1;
                        e.mux  = win && ph == 0;
                        e.vld  = win && ph == kk - 1;
                        q.push_back(e);
                    end
        e_pop  = tot * w * c;
        e_vld  = full * w * ops * c;
        e_push = full * (kk - 1) * w * ops * c;
    endtask

    always @(negedge clk) begin
        logic [4:0] expd;
        exp_t r;
        cyc++;
        if (!mon_en) begin
            for (int i = 0; i < 16; i++) ring[i] = '0;
        end else begin
            expd = ring[cyc % 16];
            ring[cyc % 16] = '0;
            if (ctrl[1] || ctrl[0]) begin
                if (q.size() == 0) begin
                    check("unexpected_issue", 32'(ctrl[1:0]), 32'd0);
                end else begin
                    r = q.pop_front();
                    check("issue_kind", 32'(ctrl[1:0]), 32'({r.pop, ~r.pop}));
                    ring[(cyc + ROWPOP_LAT) % 16] |= {r.pad, 1'b0, 1'b0, r.rpop, 1'b0};
                    ring[(cyc + PIPE_LAT) % 16]   |= {1'b0, r.vld, r.mux, 1'b0, r.push};
                    expd[4] = expd[4] | r.pad;
                end
            end
            check("row_ctrl", 32'(ctrl[6:2]), 32'(expd));
            cnt_pop  += int'(ctrl[1]);
            cnt_vld  += int'(ctrl[5]);
            cnt_push += int'(ctrl[2]);
        end
        cnt_done += int'(done);
    end

    task automatic run(input string tag, input int w, input int r, input int c, input bit k3i,
                       input int s, input bit stall, input bit poke);
        int e_pop, e_vld, e_push, n, p0;
        logic [2:0] cfg_exp;
        build(w, r, c, k3i, s, e_pop, e_vld, e_push);
        cnt_pop = 0; cnt_vld = 0; cnt_push = 0; cnt_done = 0;
        words = w[DIM_WIDTH-1:0]; rows = r[DIM_WIDTH-1:0]; chans = c[DIM_WIDTH-1:0];
        k3 = k3i; stride = s[1:0]; ready = 1'b1;
        cfg_exp = {k3i, s[1:0]};
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check({tag, "_busy_on"}, 32'(busy), 32'd1);
        check({tag, "_cfg"}, 32'(cfg), 32'(cfg_exp));
        // Inputs change after capture; the run must not see them.
        words = DIM_WIDTH'($urandom_range(1, 9)); rows = DIM_WIDTH'($urandom_range(1, 9));
        chans = DIM_WIDTH'($urandom_range(1, 3)); k3 = ~k3i; stride = (s == 2) ? 2'd1 : 2'd2;
        if (poke) begin
            repeat (3) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            check({tag, "_cfg_poke"}, 32'(cfg), 32'(cfg_exp));
        end
        if (stall) begin
            repeat (9) @(posedge clk);
            #1 ready = 1'b0;
            @(posedge clk);
            @(posedge clk); #1 p0 = cnt_pop;
            repeat (3) @(posedge clk);
            #1 ready = 1'b1;
            @(posedge clk);
            @(posedge clk); #1;
            check({tag, "_no_pop_in_stall"}, 32'(cnt_pop), 32'(p0));
        end
        n = 0;
        while (done !== 1'b1 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        check({tag, "_cfg_hold"}, 32'(cfg), 32'(cfg_exp));
        @(posedge clk); #1;
        check({tag, "_busy_off"}, 32'(busy), 32'd0);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_queue_empty"}, 32'(q.size()), 32'd0);
        check({tag, "_pops"}, 32'(cnt_pop), 32'(e_pop));
        check({tag, "_valids"}, 32'(cnt_vld), 32'(e_vld));
        check({tag, "_pushes"}, 32'(cnt_push), 32'(e_push));
        check({tag, "_done_count"}, 32'(cnt_done), 32'd1);
    endtask

    initial begin
        int e_pop, e_vld, e_push, d0;
        #2;
        check("rst_ctrl", 32'(ctrl), 32'd0);
        check("rst_cfg", 32'(cfg), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;

        run("k2s2", 2, 4, 1, 1'b0, 2, 1'b0, 1'b0);
        run("k3s1", 1, 3, 1, 1'b1, 1, 1'b0, 1'b0);
        run("stall", 2, 4, 1, 1'b0, 2, 1'b1, 1'b0);
        run("k2_trail", 2, 5, 2, 1'b0, 2, 1'b0, 1'b0);
        run("k3_trail", 1, 4, 1, 1'b1, 1, 1'b0, 1'b0);

        // Abort mid-run: async clear, no done, then a clean rerun.
        build(1, 3, 1, 1'b1, 1, e_pop, e_vld, e_push);
        words = 10'd1; rows = 10'd3; chans = 10'd1; k3 = 1'b1; stride = 2'd1; ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        mon_en = 1'b0;
        #1;
        check("abort_ctrl", 32'(ctrl), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_cfg", 32'(cfg), 32'd0);
        q.delete();
        d0 = cnt_done;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("abort_no_done", 32'(cnt_done), 32'(d0));
        mon_en = 1'b1;
        @(posedge clk); #1;
        run("post_rst", 1, 3, 1, 1'b1, 1, 1'b0, 1'b0);

        run("poke", 2, 3, 2, 1'b1, 2, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
